// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory port arbiter: FSM states and default
// timing constants.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2
    } arb_state_e;

    localparam int LAT_DEF        = 2;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 3;

    // Saturating increment of the starvation counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] max);
        return (v >= max) ? max : v + 1'b1;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Memory latency counter: cleared while idle, counts while a transaction is in
// flight, and flags the last cycle of the access.
module wait_counter
    import cpu_mem_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CNT_W'(LAT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported memory with fixed
// access latency; data has priority, bounded by a starvation counter.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int LAT        = LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        if_stall,
    output logic        d_stall,
    output logic        ram_en,
    output logic        ram_we,
    output logic        addr_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

    arb_state_e       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             we_lat;
    logic             tc;
    logic             grant_d;

    wait_counter #(.LAT(LAT)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .tc     (tc)
    );

    // Data wins unless fetch has already waited through STARVE_MAX data grants
    assign grant_d = d_req && ((starve_cnt < SMAX) || !if_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            we_lat     <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            addr_sel   <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= SERVE_D;
                        we_lat     <= d_we;
                        ram_en     <= 1'b1;
                        ram_we     <= d_we;
                        addr_sel   <= 1'b1;
                        starve_cnt <= if_req ? sat_inc(starve_cnt, SMAX) : '0;
                    end else if (if_req) begin
                        state      <= SERVE_I;
                        ram_en     <= 1'b1;
                        ram_we     <= 1'b0;
                        addr_sel   <= 1'b0;
                        starve_cnt <= '0;
                    end
                end
                SERVE_D: begin
                    if (tc) begin
                        state    <= IDLE;
                        ram_en   <= 1'b0;
                        ram_we   <= 1'b0;
                        addr_sel <= 1'b0;
                        if (!we_lat)
                            d_rdata <= ram_rdata;
                    end
                end
                SERVE_I: begin
                    if (tc) begin
                        state    <= IDLE;
                        ram_en   <= 1'b0;
                        addr_sel <= 1'b0;
                        if_rdata <= ram_rdata;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ram_en   <= 1'b0;
                    ram_we   <= 1'b0;
                    addr_sel <= 1'b0;
                end
            endcase
        end
    end

    // Addresses are steered by the external mux via addr_sel
    assign if_ack    = (state == SERVE_I) && tc;
    assign d_ack     = (state == SERVE_D) && tc;
    assign if_stall  = if_req && !if_ack;
    assign d_stall   = d_req && !d_ack;
    assign ram_wdata = d_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with default LAT=2, STARVE_MAX=4.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        if_stall;
    logic        d_stall;
    logic        ram_en;
    logic        ram_we;
    logic        addr_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .if_stall  (if_stall),
        .d_stall   (d_stall),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .addr_sel  (addr_sel),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({if_ack, d_ack, ram_en, ram_we, addr_sel} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {if_ack, d_ack, ram_en, ram_we, addr_sel});
        end
        checks++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, d_rdata);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ram_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_ram_en got %b want 0", ram_en);
        end
    endtask

    task automatic test_fetch();
        ram_rdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h100;
        tick();  // cycle 1
        checks++;
        if ({ram_en, addr_sel, ram_we, if_ack, if_stall} !== 5'b10001) begin
            errors++;
            $display("FAIL fetch_c1 got %b want 10001", {ram_en, addr_sel, ram_we, if_ack, if_stall});
        end
        tick();  // cycle 2
        checks++;
        if ({if_ack, if_stall, addr_sel} !== 3'b100) begin
            errors++;
            $display("FAIL fetch_ack got %b want 100", {if_ack, if_stall, addr_sel});
        end
        if_req = 1'b0;
        tick();  // cycle 3
        checks++;
        if (if_rdata !== 32'hDEADBEEF || if_ack !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_data got %h ack %b en %b want deadbeef 0 0", if_rdata, if_ack, ram_en);
        end
    endtask

    task automatic test_load();
        ram_rdata = 32'hCAFEF00D;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        tick();
        checks++;
        if ({ram_en, addr_sel, ram_we, d_ack, d_stall} !== 5'b11001) begin
            errors++;
            $display("FAIL load_c1 got %b want 11001", {ram_en, addr_sel, ram_we, d_ack, d_stall});
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || d_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_ack got %b%b want 10", d_ack, d_stall);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if (d_rdata !== 32'hCAFEF00D || if_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_data got %h/%h want cafef00d/deadbeef", d_rdata, if_rdata);
        end
    endtask

    task automatic test_store();
        ram_rdata = 32'h55555555;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678;
        tick();
        d_we = 1'b0;  // ram_we must follow the latched value, not the live input
        checks++;
        if ({ram_en, ram_we, addr_sel, d_ack} !== 4'b1110 || ram_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL store_c1 got %b wdata %h want 1110 12345678", {ram_en, ram_we, addr_sel, d_ack}, ram_wdata);
        end
        tick();
        checks++;
        if ({ram_we, addr_sel, d_ack} !== 3'b111) begin
            errors++;
            $display("FAIL store_ack got %b want 111", {ram_we, addr_sel, d_ack});
        end
        d_req = 1'b0;
        tick();
        checks++;
        if (d_rdata !== 32'hCAFEF00D || ram_we !== 1'b0 || addr_sel !== 1'b0) begin
            errors++;
            $display("FAIL store_hold got %h we %b sel %b want cafef00d 0 0", d_rdata, ram_we, addr_sel);
        end
    endtask

    task automatic test_contention();
        int dack_cyc = -1;
        int iack_cyc = -1;
        logic sel_c1 = 1'b0;
        logic sel_c4 = 1'b1;
        ram_rdata = 32'hA5A5A5A5;
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3004;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (cyc == 1) sel_c1 = addr_sel;
            if (cyc == 4) sel_c4 = addr_sel;
            if (d_ack) begin dack_cyc = cyc; d_req = 1'b0; end
            if (if_ack) begin iack_cyc = cyc; if_req = 1'b0; end
        end
        checks++;
        if (dack_cyc != 2 || iack_cyc != 5) begin
            errors++;
            $display("FAIL contention_timing got d%0d i%0d want d2 i5", dack_cyc, iack_cyc);
        end
        checks++;
        if (sel_c1 !== 1'b1 || sel_c4 !== 1'b0) begin
            errors++;
            $display("FAIL contention_sel got %b%b want 10", sel_c1, sel_c4);
        end
    endtask

    task automatic test_starvation();
        int d_grants = 0;
        bit got_i = 0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int cyc = 1; cyc <= 60 && !got_i; cyc++) begin
            tick();
            if (d_ack) d_grants++;
            if (if_ack) begin
                got_i = 1;
                if_req = 1'b0;
                d_req = 1'b0;
            end
        end
        checks++;
        if (!got_i || d_grants != 4) begin
            errors++;
            $display("FAIL starve_grants got fetch %0d data %0d want 1 4", got_i, d_grants);
        end
        checks++;
        if (dut.starve_cnt !== 3'd0) begin
            errors++;
            $display("FAIL starve_clear got %0d want 0", dut.starve_cnt);
        end
        tick();
    endtask

    task automatic test_drop_mid();
        ram_rdata = 32'h0BADF00D;
        if_req = 1'b1; if_addr = 32'h108;
        tick();
        if_req = 1'b0;
        tick();
        checks++;
        if (if_ack !== 1'b1) begin
            errors++;
            $display("FAIL drop_mid_ack got %b want 1", if_ack);
        end
        tick();
        checks++;
        if (if_rdata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL drop_mid_data got %h want 0badf00d", if_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int ack_cyc = -1;
        ram_rdata = 32'h77778888;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        tick();  // cycle 1 of SERVE_D
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_en, addr_sel, ram_we, d_ack} !== 4'b0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_imm got %b rdata %h want 0000 0", {ram_en, addr_sel, ram_we, d_ack}, d_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (d_ack) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_noack got ack 1 want 0");
        end
        rst = 1'b0;  // request still held: this is cycle 0 of the re-issue
        for (int cyc = 1; cyc <= 6 && ack_cyc < 0; cyc++) begin
            tick();
            if (d_ack) begin ack_cyc = cyc; d_req = 1'b0; end
        end
        checks++;
        if (ack_cyc != 2) begin
            errors++;
            $display("FAIL reset_mid_reissue got cycle %0d want 2", ack_cyc);
        end
        tick();
        checks++;
        if (d_rdata !== 32'h77778888) begin
            errors++;
            $display("FAIL reset_mid_data got %h want 77778888", d_rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        ram_rdata = '0;
        #2;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_contention();
        test_starvation();
        test_drop_mid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 2, meaning the memory access latency in cycles (legal range 1..7).
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive data grants while fetch waits.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be:
clk  in  1  clock
rst  in  1  async active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  32  fetch address, stable while if_req
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  32  registered fetch data
d_req  in  1  data request, held until d_ack
d_we  in  1  data write enable
d_addr  in  32  data address, stable while d_req
d_wdata  in  32  write data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  32  registered load data
if_stall  out  1  if_req & ~if_ack
d_stall  out  1  d_req & ~d_ack
ram_en  out  1  memory enable
ram_we  out  1  memory write enable
addr_sel  out  1  select of the external 2:1 address mux: 1 = d_addr, 0 = if_addr
ram_wdata  out  32  write data to memory
ram_rdata  in  32  memory read data

Function
REQ-005 The FSM SHALL have states IDLE, SERVE_D, SERVE_I.
REQ-006 In IDLE, d_req with (starve_cnt < STARVE_MAX or ~if_req) SHALL move to SERVE_D; otherwise if_req SHALL move to SERVE_I; otherwise stay in IDLE.
REQ-007 On entering SERVE_D, d_we SHALL be latched; ram_we SHALL equal the latched value for the whole SERVE_D stay.
REQ-008 ram_en SHALL be 1 in SERVE_D/SERVE_I, 0 in IDLE; addr_sel SHALL be 1 in SERVE_D, 0 otherwise (including IDLE).
REQ-009 ram_wdata SHALL pass d_wdata through combinationally.
REQ-010 A wait counter SHALL clear on SERVE entry and increment each cycle; on the cycle it equals LAT-1 the port's ack SHALL pulse and the FSM SHALL return to IDLE.
REQ-011 Latency: req first seen high in IDLE at cycle 0 -> ack at cycle LAT (idle arbiter, no contention).
REQ-012 On ack, ram_rdata SHALL be captured into if_rdata or d_rdata; d_rdata SHALL hold its value on write acks; both SHALL hold until that port's next read ack.
REQ-013 At least one IDLE cycle SHALL separate consecutive transactions; no re-arbitration on an ack cycle.
REQ-014 starve_cnt (3 bits) SHALL increment on each SERVE_D grant made while if_req=1, clear on a SERVE_I grant or a SERVE_D grant with if_req=0, and saturate at STARVE_MAX.
REQ-015 A requester dropping req mid-transaction SHALL NOT abort it; ack still pulses.
REQ-016 Simultaneous if_req and d_req with starve_cnt=STARVE_MAX SHALL grant fetch.

Reset
REQ-017 rst SHALL force IDLE, wait counter 0, starve_cnt 0, latched we 0, if_rdata/d_rdata 0, acks 0, ram_en/ram_we/addr_sel 0, immediately and asynchronously.
REQ-018 Reset mid-transaction SHALL abort it with no ack; the requester re-issues.

Structure
REQ-019 The state enum and default LAT/STARVE_MAX constants SHALL live in shared package cpu_mem_pkg.
REQ-020 The latency counter SHALL be a sub-module wait_counter (clear, enable, terminal-count output).

Verification
REQ-021 Single fetch, LAT=2: if_req=1, if_addr=0x100 at cycle 0, ram_rdata=0xDEADBEEF -> if_ack at cycle 2, if_rdata=0xDEADBEEF, addr_sel=0 throughout.
REQ-022 Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0x12345678 -> ram_we=1, addr_sel=1 for 2 cycles, d_ack at cycle 2, d_rdata unchanged.
REQ-023 Contention: both reqs at cycle 0 -> data served first (d_ack cycle 2), fetch granted after one IDLE cycle (if_ack cycle 5).
REQ-024 Starvation: if_req held high, d_req re-asserted after every d_ack -> exactly 4 data grants, then one fetch grant, starve_cnt back to 0.
REQ-025 Reset: assert rst at cycle 1 of a SERVE_D read -> outputs 0 immediately, no d_ack; re-issued request completes LAT cycles after deassert.
